// File: rtl/crc32_frame_engine_if.sv
// crc32_frame_engine_if: beat stream into the CRC engine and its result/status outputs.
interface crc32_frame_engine_if #(
   parameter int DATA_WIDTH = 64
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   logic [DATA_WIDTH-1:0] i_data;
   logic [KEEP_WIDTH-1:0] i_keep;
   logic                  i_valid;
   logic                  i_last;
   logic                  i_flush;
   logic [31:0]           o_crc;
   logic                  o_crc_valid;
   logic                  o_fcs_ok;
   logic                  o_err;
   logic [31:0]           o_crc_state;
   logic [15:0]           o_byte_cnt;
   modport master (
      output i_data, i_keep, i_valid, i_last, i_flush,
      input  o_crc, o_crc_valid, o_fcs_ok, o_err, o_crc_state, o_byte_cnt
   );
   modport slave (
      input  i_data, i_keep, i_valid, i_last, i_flush,
      output o_crc, o_crc_valid, o_fcs_ok, o_err, o_crc_state, o_byte_cnt
   );
endinterface

// File: rtl/crc32_frame_engine.sv
// crc32_frame_engine: one-beat-per-cycle reflected CRC-32 (IEEE 802.3) over keep-qualified frames,
// with FCS residue check, byte count and illegal-keep detection.
module crc32_frame_engine #(
   parameter int          DATA_WIDTH  = 64,
   parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] CRC_XOROUT  = 32'hFFFFFFFF,
   parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3
) (
   input logic                 i_clk,
   input logic                 i_reset_n,
   crc32_frame_engine_if.slave bus
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t      state_q, state_d;
   logic [31:0] crc_state_q, crc_state_d, crc_q, crc_d, crc_next;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [16:0] byte_sum;
   logic        crc_valid_q, crc_valid_d, fcs_ok_q, fcs_ok_d, err_q, err_d, keep_ok;

   function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d,
                                              input logic [KEEP_WIDTH-1:0] k);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < KEEP_WIDTH; i++)
         for (int j = 0; j < 8; j++)
            if (k[i]) r = {1'b0, r[31:1]} ^ ((r[0] ^ d[8*i+j]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   always_comb begin
      keep_ok = bus.i_last ? (bus.i_keep != '0 && (bus.i_keep & (bus.i_keep + KEEP_ONE)) == '0)
                           : &bus.i_keep;
      crc_next = crc_update(state_q == ACTIVE ? crc_state_q : CRC_INIT, bus.i_data, bus.i_keep);
      byte_sum = (state_q == ACTIVE ? {1'b0, byte_cnt_q} : 17'd0) + 17'($countones(bus.i_keep));
      state_d = state_q;
      crc_state_d = crc_state_q;
      crc_d = crc_q;
      byte_cnt_d = byte_cnt_q;
      fcs_ok_d = fcs_ok_q;
      crc_valid_d = 1'b0;
      err_d = 1'b0;
      // flush beats any beat presented alongside it
      if (bus.i_flush) begin
         state_d = IDLE;
         crc_state_d = CRC_INIT;
         byte_cnt_d = '0;
      end else if (bus.i_valid && !keep_ok) begin
         state_d = IDLE;
         err_d = 1'b1;
      end else if (bus.i_valid) begin
         state_d = bus.i_last ? IDLE : ACTIVE;
         crc_state_d = crc_next;
         byte_cnt_d = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
         crc_valid_d = bus.i_last;
         crc_d = bus.i_last ? crc_next ^ CRC_XOROUT : crc_q;
         fcs_ok_d = bus.i_last ? crc_next == CRC_RESIDUE : fcs_ok_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state_q <= IDLE;
         crc_state_q <= CRC_INIT;
         crc_q <= '0;
         byte_cnt_q <= '0;
         crc_valid_q <= 1'b0;
         fcs_ok_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_state_q <= crc_state_d;
         crc_q <= crc_d;
         byte_cnt_q <= byte_cnt_d;
         crc_valid_q <= crc_valid_d;
         fcs_ok_q <= fcs_ok_d;
         err_q <= err_d;
      end

   assign bus.o_crc = crc_q;
   assign bus.o_crc_valid = crc_valid_q;
   assign bus.o_fcs_ok = fcs_ok_q;
   assign bus.o_err = err_q;
   assign bus.o_crc_state = crc_state_q;
   assign bus.o_byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_crc32_frame_engine.sv
// tb_crc32_frame_engine: 32- and 64-bit engines checked every cycle against a table-driven byte-level
// CRC model, plus literal check values for the model itself.
module tb_crc32_frame_engine;
   localparam logic [31:0] INIT = 32'hFFFFFFFF, XOROUT = 32'hFFFFFFFF, RESIDUE = 32'hDEBB20E3;
   localparam logic [127:0] FCS_FRAME = {24'h0, 8'hCB, 32'hF4392639, 32'h38373635, 32'h34333231};
   logic        clk = 1'b0, rst_n = 1'b1;
   logic [63:0] s_data = '0;
   logic [7:0]  s_keep = '0;
   logic        s_valid = 1'b0, s_last = 1'b0, s_flush = 1'b0, sel = 1'b0;
   int          n_vec = 0, n_err = 0, pulses64 = 0, nbeats;
   logic [8:0]  tk;
   logic [31:0] tbl [256];
   logic        m_active [2], m_valid [2], m_fcs [2], m_err [2];
   logic [31:0] m_state [2], m_crc [2];
   int          m_cnt [2];
   logic        mv, mf, mok;
   logic [7:0]  mk;
   logic [31:0] mc;
   int          mpc;

   always #5 clk = ~clk;

   crc32_frame_engine_if #(.DATA_WIDTH(32)) if32();
   crc32_frame_engine_if #(.DATA_WIDTH(64)) if64();
   assign if32.i_data = s_data[31:0];
   assign if32.i_keep = s_keep[3:0];
   assign if32.i_valid = s_valid & ~sel;
   assign if32.i_last = s_last;
   assign if32.i_flush = s_flush & ~sel;
   assign if64.i_data = s_data;
   assign if64.i_keep = s_keep;
   assign if64.i_valid = s_valid & sel;
   assign if64.i_last = s_last;
   assign if64.i_flush = s_flush & sel;

   crc32_frame_engine #(.DATA_WIDTH(32)) u32 (.i_clk(clk), .i_reset_n(rst_n), .bus(if32.slave));
   crc32_frame_engine #(.DATA_WIDTH(64)) u64 (.i_clk(clk), .i_reset_n(rst_n), .bus(if64.slave));

   initial
      for (int n = 0; n < 256; n++) begin
         tbl[n] = 32'(n);
         for (int b = 0; b < 8; b++) tbl[n] = tbl[n][0] ? (tbl[n] >> 1) ^ 32'hEDB88320 : tbl[n] >> 1;
      end

   // model: frame-level view, CRC advanced a whole byte at a time through the lookup table
   always @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_state[d] = INIT; m_crc[d] = 0; m_cnt[d] = 0;
            m_valid[d] = 0; m_fcs[d] = 0; m_err[d] = 0;
         end
      else
         for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_err[d] = 0;
            mv = s_valid && (sel == d[0]);
            mf = s_flush && (sel == d[0]);
            mk = s_keep & (d == 1 ? 8'hFF : 8'h0F);
            mok = s_last ? (mk != 0 && (mk & (mk + 8'd1)) == 0) : (mk == (d == 1 ? 8'hFF : 8'h0F));
            if (mf) begin
               m_active[d] = 0; m_state[d] = INIT; m_cnt[d] = 0;
            end else if (mv && !mok) begin
               m_err[d] = 1; m_active[d] = 0;
            end else if (mv) begin
               mc = m_active[d] ? m_state[d] : INIT;
               mpc = 0;
               for (int i = 0; i < (d == 1 ? 8 : 4); i++)
                  if (mk[i]) begin
                     mc = tbl[mc[7:0] ^ s_data[8*i+:8]] ^ (mc >> 8);
                     mpc++;
                  end
               m_state[d] = mc;
               m_cnt[d] = (m_active[d] ? m_cnt[d] : 0) + mpc;
               if (m_cnt[d] > 65535) m_cnt[d] = 65535;
               if (s_last) begin
                  m_valid[d] = 1; m_crc[d] = mc ^ XOROUT; m_fcs[d] = (mc == RESIDUE); m_active[d] = 0;
               end else m_active[d] = 1;
            end
         end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string n, input int d, input logic v, input logic e, input logic [31:0] c,
                      input logic f, input logic [31:0] st, input logic [15:0] bc);
      chk({n, " crc_valid"}, 32'(v), 32'(m_valid[d]));
      chk({n, " err"}, 32'(e), 32'(m_err[d]));
      chk({n, " crc"}, c, m_crc[d]);
      chk({n, " fcs_ok"}, 32'(f), 32'(m_fcs[d]));
      chk({n, " crc_state"}, st, m_state[d]);
      chk({n, " byte_cnt"}, 32'(bc), 32'(m_cnt[d]));
   endtask

   always @(negedge clk) begin
      cmp("u32", 0, if32.o_crc_valid, if32.o_err, if32.o_crc, if32.o_fcs_ok, if32.o_crc_state, if32.o_byte_cnt);
      cmp("u64", 1, if64.o_crc_valid, if64.o_err, if64.o_crc, if64.o_fcs_ok, if64.o_crc_state, if64.o_byte_cnt);
      if (if64.o_crc_valid) pulses64++;
   end

   task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic f = 1'b0);
      s_data = d; s_keep = k; s_last = l; s_valid = 1'b1; s_flush = f;
      @(posedge clk); #2;
      s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic crc9(input string n);
      drive(64'h34333231, 8'h0F, 0);
      drive(64'h38373635, 8'h0F, 0);
      drive(64'h00000039, 8'h01, 1);
      chk({n, " lit crc"}, if32.o_crc, 32'hCBF43926);
      chk({n, " lit byte_cnt"}, 32'(if32.o_byte_cnt), 32'd9);
      chk({n, " lit crc_valid"}, 32'(if32.o_crc_valid), 32'd1);
   endtask

   task automatic fcs_frame(input logic [127:0] x, input logic exp_ok);
      drive(64'(x[31:0]), 8'h0F, 0);
      drive(64'(x[63:32]), 8'h0F, 0);
      drive(64'(x[95:64]), 8'h0F, 0);
      drive(64'(x[127:96]), 8'h01, 1);
      chk("lit fcs_ok", 32'(if32.o_fcs_ok), 32'(exp_ok));
      chk("lit fcs byte_cnt", 32'(if32.o_byte_cnt), 32'd13);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset crc_state", if32.o_crc_state, INIT);
      chk("reset crc", if32.o_crc, 32'h0);
      chk("reset valid/err/fcs", {29'h0, if32.o_crc_valid, if32.o_err, if32.o_fcs_ok}, 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      idle(1);
      crc9("check");
      idle(1);
      chk("valid one pulse", 32'(if32.o_crc_valid), 32'd0);
      chk("crc holds", if32.o_crc, 32'hCBF43926);
      drive(64'h34333231, 8'h0F, 0);
      idle(2);
      drive(64'h38373635, 8'h0F, 0);
      idle(1);
      drive(64'h00000039, 8'h01, 1);
      chk("gap lit crc", if32.o_crc, 32'hCBF43926);
      crc9("back2back");
      fcs_frame(FCS_FRAME, 1'b1);
      fcs_frame(FCS_FRAME ^ (128'd1 << 0), 1'b0);
      fcs_frame(FCS_FRAME ^ (128'd1 << 77), 1'b0);
      fcs_frame(FCS_FRAME ^ (128'd1 << 103), 1'b0);
      drive(64'h34333231, 8'h0F, 0);
      drive(64'h38373635, 8'h07, 0);
      chk("mid keep err", 32'(if32.o_err), 32'd1);
      chk("mid keep no valid", 32'(if32.o_crc_valid), 32'd0);
      crc9("after mid err");
      drive(64'h34333231, 8'h0F, 0);
      drive(64'h38373635, 8'h05, 1);
      chk("last keep err", 32'(if32.o_err), 32'd1);
      chk("last keep no valid", 32'(if32.o_crc_valid), 32'd0);
      drive(64'h0, 8'h00, 1);
      chk("zero keep err", 32'(if32.o_err), 32'd1);
      crc9("after last err");
      drive(64'h34333231, 8'h0F, 0);
      drive(64'h38373635, 8'h0F, 1, 1);
      chk("flush no valid/err", {30'h0, if32.o_crc_valid, if32.o_err}, 32'h0);
      chk("flush crc_state", if32.o_crc_state, INIT);
      chk("flush byte_cnt", 32'(if32.o_byte_cnt), 32'd0);
      crc9("after flush");
      drive(64'h34333231, 8'h0F, 0);
      rst_n = 1'b0;
      #3;
      chk("mid reset crc_state", if32.o_crc_state, INIT);
      chk("mid reset crc", if32.o_crc, 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      crc9("after reset");
      sel = 1'b1;
      drive(64'h3837363534333231, 8'hFF, 0);
      drive(64'h39, 8'h01, 1);
      chk("w64 lit crc", if64.o_crc, 32'hCBF43926);
      chk("w64 lit byte_cnt", 32'(if64.o_byte_cnt), 32'd9);
      idle(1);
      pulses64 = 0;
      for (int fr = 0; fr < 60; fr++) begin
         nbeats = $urandom_range(1, 4);
         for (int b = 0; b < nbeats; b++) begin
            tk = (9'd1 << $urandom_range(1, 8)) - 9'd1;
            drive({$urandom, $urandom}, b == nbeats - 1 ? tk[7:0] : 8'hFF, b == nbeats - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      idle(2);
      chk("w64 pulses per frame", 32'(pulses64), 32'd60);
      for (int b = 0; b < 8192; b++) drive({$urandom, $urandom}, 8'hFF, 0);
      drive({$urandom, $urandom}, 8'hFF, 1);
      chk("w64 byte_cnt saturates", 32'(if64.o_byte_cnt), 32'h0000FFFF);
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
